// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and constants for the two-port ROM read arbiter.
// Grant encoding doubles as the index of the per-port response registers.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   localparam int unsigned MEM_BYTES_DEFAULT = 4096;
   localparam logic [1:0]  ALIGN_MASK        = 2'b11;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Bundle of the fetch/load request ports and the memory read port.
// slave is the arbiter side, master is the requester/memory side.
interface rom_read_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_data;
   logic              i_err;

   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_ack;
   logic [DATA_W-1:0] d_data;
   logic              d_err;

   logic              m_cs;
   logic              m_rd;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_dout;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, m_dout,
      output i_ack, i_data, i_err, d_ack, d_data, d_err, m_cs, m_rd, m_addr
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, m_dout,
      input  i_ack, i_data, i_err, d_ack, d_data, d_err, m_cs, m_rd, m_addr
   );
endinterface

// File: rtl/rom_read_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between fetch and load.
// Under contention the port that did not win last time is chosen.
module rr_arbiter2
   import rom_arb_pkg::*;
(
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic last_grant_i,
   output logic grant_o
);

   always_comb begin
      grant_o = GNT_I;
      if (i_req_i && d_req_i) begin
         grant_o = ~last_grant_i;
      end else if (d_req_i) begin
         grant_o = GNT_D;
      end
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one ROM read port between instruction fetch and data load.
// IDLE grants and screens the address, READ strobes the memory, DONE acks.
module rom_read_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   rom_read_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              strobe_q, strobe_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;

   logic              pick;
   logic [ADDR_W-1:0] req_addr;
   logic              addr_bad;

   logic              resp_valid;
   logic              resp_port;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;

   logic              ack_q  [2];
   logic [DATA_W-1:0] data_q [2];
   logic              err_q  [2];

   rr_arbiter2 u_rr (
      .i_req_i      (bus.i_req),
      .d_req_i      (bus.d_req),
      .last_grant_i (last_grant_q),
      .grant_o      (pick)
   );

   assign req_addr = (pick == GNT_D) ? bus.d_addr : bus.i_addr;
   // Unsigned full-width compare, so addresses near 2^32 cannot wrap into range.
   assign addr_bad = ((req_addr[1:0] & ALIGN_MASK) != 2'b00) || (req_addr > LAST_WORD);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      strobe_d     = 1'b0;
      m_addr_d     = m_addr_q;
      resp_valid   = 1'b0;
      resp_port    = grant_q;
      resp_data    = '0;
      resp_err     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_d   = pick;
               resp_port = pick;
               if (addr_bad) begin
                  resp_valid = 1'b1;
                  resp_err   = 1'b1;
                  state_d    = DONE;
               end else begin
                  strobe_d = 1'b1;
                  m_addr_d = req_addr;
                  state_d  = READ;
               end
            end
         end
         READ: begin
            resp_valid = 1'b1;
            resp_data  = bus.m_dout;
            state_d    = DONE;
         end
         DONE: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= GNT_I;
         last_grant_q <= GNT_D;
         strobe_q     <= 1'b0;
         m_addr_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         strobe_q     <= strobe_d;
         m_addr_q     <= m_addr_d;
      end
   end

   // Index 0 is the fetch port, index 1 the load port, matching the grant code.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clk) begin
         if (reset) begin
            ack_q[gi]  <= 1'b0;
            data_q[gi] <= '0;
            err_q[gi]  <= 1'b0;
         end else begin
            ack_q[gi] <= resp_valid && (resp_port == 1'(gi));
            if (resp_valid && (resp_port == 1'(gi))) begin
               data_q[gi] <= resp_data;
               err_q[gi]  <= resp_err;
            end
         end
      end
   end

   assign bus.m_cs   = strobe_q;
   assign bus.m_rd   = strobe_q;
   assign bus.m_addr = m_addr_q;
   assign bus.i_ack  = ack_q[0];
   assign bus.i_data = data_q[0];
   assign bus.i_err  = err_q[0];
   assign bus.d_ack  = ack_q[1];
   assign bus.d_data = data_q[1];
   assign bus.d_err  = err_q[1];

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: a byte ROM model answers m_cs/m_rd,
// expected responses are queued at request time and popped on each ack.
module tb_rom_read_arbiter;

   localparam logic PI = 1'b0;
   localparam logic PD = 1'b1;

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   exp_t sb [$];
   logic [7:0] mem [0:4095];

   rom_read_arbiter_if bus_if ();

   rom_read_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   always_comb begin
      logic [11:0] a;
      a = bus_if.m_addr[11:0];
      bus_if.m_dout = 32'h0;
      if (bus_if.m_cs && bus_if.m_rd && bus_if.m_addr < 32'd4093)
         bus_if.m_dout = {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
   end

   function automatic logic [31:0] exp_word(input logic [31:0] addr);
      logic [11:0] a;
      a = addr[11:0];
      return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
   endfunction

   function automatic logic exp_bad(input logic [31:0] addr);
      return (addr % 4 != 0) || (addr > 32'd4092);
   endfunction

   // Scoreboard: every ack pops the oldest expectation.
   always @(negedge clk) begin
      if (bus_if.i_ack && bus_if.d_ack) begin
         errors++;
         $display("FAIL dual_ack: got i_ack=1 d_ack=1 want at most one");
      end
      if (bus_if.i_ack || bus_if.d_ack) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b want none", bus_if.i_ack, bus_if.d_ack);
         end else begin
            exp_t e;
            logic        p;
            logic [31:0] dat;
            logic        er;
            e   = sb.pop_front();
            p   = bus_if.d_ack;
            dat = p ? bus_if.d_data : bus_if.i_data;
            er  = p ? bus_if.d_err : bus_if.i_err;
            if ({p, dat, er} !== {e.port, e.data, e.err}) begin
               errors++;
               $display("FAIL sb_resp: got port=%b data=%h err=%b want port=%b data=%h err=%b",
                        p, dat, er, e.port, e.data, e.err);
            end else begin
               $display("ack port=%s data=%h err=%b", p ? "D" : "I", dat, er);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      bus_if.i_req = 1'b0; bus_if.d_req = 1'b0;
      bus_if.i_addr = '0;  bus_if.d_addr = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_if.m_cs, bus_if.m_rd, bus_if.i_ack, bus_if.d_ack, bus_if.i_err, bus_if.d_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {bus_if.m_cs, bus_if.m_rd, bus_if.i_ack, bus_if.d_ack, bus_if.i_err, bus_if.d_err});
      end
      checks++;
      if ({bus_if.m_addr, bus_if.i_data, bus_if.d_data} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data: got m_addr=%h i_data=%h d_data=%h want 0",
                  bus_if.m_addr, bus_if.i_data, bus_if.d_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_fetch();
      @(negedge clk);
      bus_if.i_addr = 32'h10; bus_if.i_req = 1'b1;
      sb.push_back('{port: PI, data: 32'hDEAD_BEEF, err: 1'b0});
      @(negedge clk);
      checks++;
      if ({bus_if.m_cs, bus_if.m_rd, bus_if.m_addr, bus_if.i_ack} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
         errors++;
         $display("FAIL fetch_strobe: got cs=%b rd=%b addr=%h ack=%b want 1 1 00000010 0",
                  bus_if.m_cs, bus_if.m_rd, bus_if.m_addr, bus_if.i_ack);
      end
      @(negedge clk);
      checks++;
      if ({bus_if.i_ack, bus_if.i_data, bus_if.i_err, bus_if.m_cs} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fetch_ack: got ack=%b data=%h err=%b cs=%b want 1 deadbeef 0 0",
                  bus_if.i_ack, bus_if.i_data, bus_if.i_err, bus_if.m_cs);
      end
      bus_if.i_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_if.i_ack, bus_if.m_cs} !== 2'b00) begin
         errors++;
         $display("FAIL fetch_idle: got ack=%b cs=%b want 0 0", bus_if.i_ack, bus_if.m_cs);
      end
   endtask

   task automatic test_contention();
      int         nacks = 0;
      int         last_c = 0;
      logic [3:0] order = 4'b0;
      reset = 1'b1;
      bus_if.i_addr = 32'h20; bus_if.d_addr = 32'h40;
      bus_if.i_req = 1'b1; bus_if.d_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic p;
         p = 1'(k & 1);
         sb.push_back('{port: p, data: exp_word(p ? 32'h40 : 32'h20), err: 1'b0});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 40 && nacks < 4; c++) begin
         @(negedge clk);
         if (bus_if.i_ack || bus_if.d_ack) begin
            order[nacks] = bus_if.d_ack;
            if (nacks > 0) begin
               checks++;
               if (c - last_c != 3) begin
                  errors++;
                  $display("FAIL rr_spacing: got %0d cycles want 3", c - last_c);
               end
            end
            last_c = c;
            nacks++;
         end
      end
      bus_if.i_req = 1'b0; bus_if.d_req = 1'b0;
      checks++;
      if (nacks != 4) begin
         errors++;
         $display("FAIL rr_timeout: got %0d acks want 4", nacks);
      end
      checks++;
      if (order !== 4'b1010) begin
         errors++;
         $display("FAIL rr_order: got %b want 1010 (bit0 first, 0=I 1=D)", order);
      end
   endtask

   task automatic test_bad_align();
      @(negedge clk);
      bus_if.d_addr = 32'h6; bus_if.d_req = 1'b1;
      sb.push_back('{port: PD, data: 32'h0, err: 1'b1});
      @(negedge clk);
      checks++;
      if ({bus_if.d_ack, bus_if.d_err, bus_if.d_data, bus_if.m_cs} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL misalign: got ack=%b err=%b data=%h cs=%b want 1 1 00000000 0",
                  bus_if.d_ack, bus_if.d_err, bus_if.d_data, bus_if.m_cs);
      end
      bus_if.d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.m_cs !== 1'b0) begin
         errors++;
         $display("FAIL misalign_cs: got %b want 0", bus_if.m_cs);
      end
   endtask

   task automatic test_range();
      logic [31:0] addrs [3];
      addrs = '{32'h0000_0FFC, 32'h0000_1000, 32'hFFFF_FFFC};
      foreach (addrs[k]) begin
         logic bad;
         int   lat = 0;
         int   cs_seen = 0;
         logic got = 1'b0;
         logic er = 1'b0;
         bad = exp_bad(addrs[k]);
         @(negedge clk);
         bus_if.i_addr = addrs[k]; bus_if.i_req = 1'b1;
         sb.push_back('{port: PI, data: bad ? 32'h0 : exp_word(addrs[k]), err: bad});
         for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (bus_if.m_cs) cs_seen++;
            if (bus_if.i_ack) begin
               got = 1'b1; lat = c; er = bus_if.i_err;
               bus_if.i_req = 1'b0;
            end
         end
         bus_if.i_req = 1'b0;
         checks++;
         if (lat != (bad ? 1 : 2) || cs_seen != (bad ? 0 : 1) || er !== bad) begin
            errors++;
            $display("FAIL range_%h: got lat=%0d cs=%0d err=%b want lat=%0d cs=%0d err=%b",
                     addrs[k], lat, cs_seen, er, bad ? 1 : 2, bad ? 0 : 1, bad);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus_if.i_addr = 32'h100; bus_if.i_req = 1'b1;
      sb.push_back('{port: PI, data: exp_word(32'h100), err: 1'b0});
      @(negedge clk);
      bus_if.i_addr = 32'h200;
      @(negedge clk);
      checks++;
      if ({bus_if.i_ack, bus_if.i_data} !== {1'b1, exp_word(32'h100)}) begin
         errors++;
         $display("FAIL b2b_latched: got ack=%b data=%h want 1 %h", bus_if.i_ack, bus_if.i_data, exp_word(32'h100));
      end
      bus_if.i_addr = 32'h300;
      sb.push_back('{port: PI, data: exp_word(32'h300), err: 1'b0});
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus_if.m_cs, bus_if.m_addr} !== {1'b1, 32'h300}) begin
         errors++;
         $display("FAIL b2b_reissue: got cs=%b addr=%h want 1 00000300", bus_if.m_cs, bus_if.m_addr);
      end
      @(negedge clk);
      checks++;
      if (bus_if.i_ack !== 1'b1) begin
         errors++;
         $display("FAIL b2b_spacing: got ack=%b want 1 three cycles after previous", bus_if.i_ack);
      end
      bus_if.i_req = 1'b0;
   endtask

   task automatic test_reset_in_read();
      int   nacks = 0;
      logic first = 1'b1;
      @(negedge clk);
      bus_if.i_addr = 32'h100; bus_if.i_req = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.m_cs !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup: got cs=%b want 1", bus_if.m_cs);
      end
      reset = 1'b1; bus_if.i_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_if.m_cs, bus_if.i_ack, bus_if.d_ack} !== 3'b000) begin
         errors++;
         $display("FAIL abort: got cs=%b i_ack=%b d_ack=%b want 0 0 0", bus_if.m_cs, bus_if.i_ack, bus_if.d_ack);
      end
      @(negedge clk);
      reset = 1'b0;
      bus_if.i_addr = 32'h104; bus_if.d_addr = 32'h108;
      bus_if.i_req = 1'b1; bus_if.d_req = 1'b1;
      sb.push_back('{port: PI, data: exp_word(32'h104), err: 1'b0});
      sb.push_back('{port: PD, data: exp_word(32'h108), err: 1'b0});
      for (int c = 0; c < 20 && nacks < 2; c++) begin
         @(negedge clk);
         if (bus_if.i_ack || bus_if.d_ack) begin
            if (nacks == 0) first = bus_if.d_ack;
            if (bus_if.i_ack) bus_if.i_req = 1'b0;
            if (bus_if.d_ack) bus_if.d_req = 1'b0;
            nacks++;
         end
      end
      bus_if.i_req = 1'b0; bus_if.d_req = 1'b0;
      checks++;
      if (nacks != 2 || first !== PI) begin
         errors++;
         $display("FAIL post_reset_rr: got acks=%0d first=%b want 2 0", nacks, first);
      end
   endtask

   task automatic test_drop_in_read();
      int extra = 0;
      @(negedge clk);
      bus_if.d_addr = 32'h80; bus_if.d_req = 1'b1;
      sb.push_back('{port: PD, data: exp_word(32'h80), err: 1'b0});
      @(negedge clk);
      bus_if.d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.d_ack !== 1'b1) begin
         errors++;
         $display("FAIL drop_ack: got %b want 1", bus_if.d_ack);
      end
      repeat (5) begin
         @(negedge clk);
         if (bus_if.d_ack || bus_if.i_ack || bus_if.m_cs) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL drop_quiet: got %0d active cycles want 0", extra);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11) ^ 8'(i >> 8);
      mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
      test_reset();
      test_basic_fetch();
      test_contention();
      test_bad_align();
      test_range();
      test_back_to_back();
      test_reset_in_read();
      test_drop_in_read();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
